// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state codes and port IDs for mem_arbiter
// Contents: state_t, ST_IDLE/ST_ACCESS/ST_RESP, PORT_I/PORT_D.
package mem_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_RESP   = 2'd2;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side bus bundle for mem_arbiter
// Ports: I port (i_req/i_addr/i_ack/i_rdata), D port (d_req/d_we/d_addr/d_wdata/d_ack/d_rdata),
//        RAM port (ram_we/ram_addr/ram_wdata/ram_rdata).
// Modports: slave = arbiter view, master = requester + RAM environment view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
// Ports: req_i, req_d (requests), last (port granted last), mask_i, mask_d (exclude a port),
//        gnt (0 = I, 1 = D; meaningless when no unmasked request).
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last,
   input  logic mask_i,
   input  logic mask_d,
   output logic gnt
);

   logic elig_i;
   logic elig_d;

   assign elig_i = req_i & ~mask_i;
   assign elig_d = req_d & ~mask_d;

   // On a tie the port that did not win last time takes it.
   always_comb begin
      if (elig_i && elig_d) begin
         gnt = ~last;
      end else if (elig_d) begin
         gnt = PORT_D;
      end else begin
         gnt = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D arbiter and sequencer for a single-port synchronous-read RAM
// Ports: clk (also RAM clock), rst_n (sync, active low),
//        bus (mem_arbiter_if.slave: I/D request ports and RAM port).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic mask_i;
   logic mask_d;
   logic arb_gnt;
   logic arb_any;
   logic take;
   logic i_ack;
   logic d_ack;

   // In RESP the port being acked cannot be re-granted; only the other port may
   // start a back-to-back access.
   assign mask_i = (state_q == ST_RESP) && (gnt_q == PORT_I);
   assign mask_d = (state_q == ST_RESP) && (gnt_q == PORT_D);

   rr_arb2 u_rr_arb2 (
      .req_i  (bus.i_req),
      .req_d  (bus.d_req),
      .last   (last_q),
      .mask_i (mask_i),
      .mask_d (mask_d),
      .gnt    (arb_gnt)
   );

   assign arb_any = (bus.i_req & ~mask_i) | (bus.d_req & ~mask_d);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      take    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            take = arb_any;
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            take = arb_any;
            if (!arb_any) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (take) begin
         state_d = ST_ACCESS;
         gnt_d   = arb_gnt;
         last_d  = arb_gnt;
         if (arb_gnt == PORT_D) begin
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
         end else begin
            // Instruction fetches are always reads.
            addr_d  = bus.i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         gnt_q     <= PORT_I;
         last_q    <= PORT_D;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         if (i_ack) begin
            i_rdata_q <= bus.ram_rdata;
         end
         if (d_ack) begin
            d_rdata_q <= bus.ram_rdata;
         end
      end
   end

   assign i_ack = (state_q == ST_RESP) && (gnt_q == PORT_I);
   assign d_ack = (state_q == ST_RESP) && (gnt_q == PORT_D);

   assign bus.i_ack   = i_ack;
   assign bus.d_ack   = d_ack;
   assign bus.i_rdata = i_ack ? bus.ram_rdata : i_rdata_q;
   assign bus.d_rdata = d_ack ? bus.ram_rdata : d_rdata_q;

   // rst_n gates the write strobe so a reset landing in ACCESS cannot write.
   assign bus.ram_we    = we_q & (state_q == ST_ACCESS) & rst_n;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Synchronous-read RAM model, word addressed by bits [13:2].
   logic [DATA_W-1:0] mem [0:4095];
   logic              pre_we = 1'b0;
   logic [11:0]       pre_idx = 12'd0;
   logic [DATA_W-1:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (bus.ram_we) mem[bus.ram_addr[13:2]] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr[13:2]];
   end

   logic [DATA_W-1:0] shadow [0:4095];
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One isolated transaction from IDLE: ACCESS at n+1, ack at n+2.
   task automatic do_vec(input vec_t v);
      if (v.port == PORT_D) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = v.addr;
      end
      tick();
      check1("vec_access_ram_we", bus.ram_we, v.we);
      check32("vec_access_ram_addr", bus.ram_addr, v.addr);
      check1("vec_access_no_ack", bus.i_ack | bus.d_ack, 1'b0);
      tick();
      check1("vec_resp_ram_we", bus.ram_we, 1'b0);
      check1("vec_ack_i", bus.i_ack, v.port == PORT_I);
      check1("vec_ack_d", bus.d_ack, v.port == PORT_D);
      if (!v.we) begin
         if (v.port == PORT_D) check32("vec_d_rdata", bus.d_rdata, v.exp_rdata);
         else                  check32("vec_i_rdata", bus.i_rdata, v.exp_rdata);
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      tick();
      check1("vec_idle_no_ack", bus.i_ack | bus.d_ack, 1'b0);
      if (v.we) shadow[v.addr[13:2]] = v.wdata;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] r;
      r = $urandom;
      return (r & 32'hFFFF_C003) | (32'($urandom_range(0, 127)) << 2);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ip, dp, dw, i_acked, d_acked;
      int          i_start, d_start;
      logic [31:0] ia, da, dwd;
      vec_t        v;

      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      vecs[0] = '{PORT_D, 1'b0, 32'h0000_0040, 32'h0,          32'h1234_5678};
      vecs[1] = '{PORT_I, 1'b0, 32'h0000_0040, 32'h0,          32'h1234_5678};
      vecs[2] = '{PORT_D, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF,  32'h0};
      vecs[3] = '{PORT_D, 1'b0, 32'h0000_0080, 32'h0,          32'hDEAD_BEEF};
      vecs[4] = '{PORT_I, 1'b0, 32'h0000_0083, 32'h0,          32'hDEAD_BEEF};
      vecs[5] = '{PORT_D, 1'b1, 32'h0000_4004, 32'hCAFE_F00D,  32'h0};
      vecs[6] = '{PORT_I, 1'b0, 32'h0000_0004, 32'h0,          32'hCAFE_F00D};
      vecs[7] = '{PORT_D, 1'b0, 32'hFFFF_4004, 32'h0,          32'hCAFE_F00D};
      vecs[8] = '{PORT_I, 1'b0, 32'h0000_0100, 32'h0,          32'h0};

      // Preload RAM words 0..127 while in reset; word 0x40>>2 holds a known value.
      pre_we = 1'b1;
      for (int k = 0; k < 128; k++) begin
         pre_idx = 12'(k);
         pre_data = (k == 16) ? 32'h1234_5678 : 32'h0;
         shadow[k] = pre_data;
         tick();
      end
      pre_we = 1'b0;

      // Reset held with a write request pending.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
         tick();
         check1("rst_ram_we", bus.ram_we, 1'b0);
         check1("rst_i_ack", bus.i_ack, 1'b0);
         check1("rst_d_ack", bus.d_ack, 1'b0);
         check32("rst_ram_addr", bus.ram_addr, 32'h0);
      end
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 9; k++) do_vec(vecs[k]);

      // Reset landing in the ACCESS cycle of a write.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hA5A5_A5A5;
      tick();
      check1("midrst_we_before", bus.ram_we, 1'b1);
      rst_n = 1'b0;
      #1;
      check1("midrst_we_forced_low", bus.ram_we, 1'b0);
      tick();
      rst_n = 1'b1; bus.d_req = 1'b0; bus.d_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check1("midrst_no_d_ack", bus.d_ack, 1'b0);
         tick();
      end
      v = '{PORT_I, 1'b0, 32'h0000_0100, 32'h0, 32'h0};
      do_vec(v);

      // Contention straight after reset: I first, then alternating every 2 cycles.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.i_req = 1'b1; bus.i_addr = 32'h40;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
      tick();
      check32("cont_first_addr", bus.ram_addr, 32'h40);
      tick();
      check1("cont_n2_i_ack", bus.i_ack, 1'b1);
      check1("cont_n2_d_ack", bus.d_ack, 1'b0);
      check32("cont_n2_i_rdata", bus.i_rdata, 32'h1234_5678);
      tick();
      check1("cont_n3_no_ack", bus.i_ack | bus.d_ack, 1'b0);
      tick();
      check1("cont_n4_d_ack", bus.d_ack, 1'b1);
      check1("cont_n4_i_ack", bus.i_ack, 1'b0);
      check32("cont_n4_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
      check32("cont_n4_i_hold", bus.i_rdata, 32'h1234_5678);
      for (int k = 5; k <= 12; k++) begin
         tick();
         if (k % 2 == 1) begin
            check1("cont_gap_no_ack", bus.i_ack | bus.d_ack, 1'b0);
         end else begin
            check1("cont_alt_i_ack", bus.i_ack, (k / 2) % 2 == 1);
            check1("cont_alt_d_ack", bus.d_ack, (k / 2) % 2 == 0);
         end
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick();
      tick();

      // Randomized requesters against a transaction-level model.
      ip = 1'b0; dp = 1'b0; dw = 1'b0;
      i_start = 0; d_start = 0; ia = '0; da = '0; dwd = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         i_acked = 1'b0; d_acked = 1'b0;
         if (bus.ram_we) begin
            check1("rnd_we_owner", dp & dw, 1'b1);
            check32("rnd_we_addr", bus.ram_addr, da);
            check32("rnd_we_data", bus.ram_wdata, dwd);
         end
         if (bus.i_ack) begin
            check1("rnd_i_owner", ip, 1'b1);
            check1("rnd_i_excl", bus.d_ack, 1'b0);
            check1("rnd_i_latency", (cyc - i_start) inside {[2:4]}, 1'b1);
            check32("rnd_i_rdata", bus.i_rdata, shadow[ia[13:2]]);
            ip = 1'b0; i_acked = 1'b1;
         end
         if (bus.d_ack) begin
            check1("rnd_d_owner", dp, 1'b1);
            check1("rnd_d_latency", (cyc - d_start) inside {[2:4]}, 1'b1);
            if (dw) shadow[da[13:2]] = dwd;
            else    check32("rnd_d_rdata", bus.d_rdata, shadow[da[13:2]]);
            dp = 1'b0; d_acked = 1'b1;
         end
         if (ip && (cyc - i_start) > 6) begin
            tests++; fails++;
            $display("FAIL rnd_i_timeout: no ack after %0d cycles, required <= 4", cyc - i_start);
            ip = 1'b0;
         end
         if (dp && (cyc - d_start) > 6) begin
            tests++; fails++;
            $display("FAIL rnd_d_timeout: no ack after %0d cycles, required <= 4", cyc - d_start);
            dp = 1'b0;
         end
         if (!ip) begin
            if ($urandom_range(0, 1) == 1) begin
               ia = rnd_addr();
               ip = 1'b1;
               i_start = i_acked ? cyc + 1 : cyc;
               bus.i_req = 1'b1; bus.i_addr = ia;
            end else begin
               bus.i_req = 1'b0;
            end
         end
         if (!dp) begin
            if ($urandom_range(0, 1) == 1) begin
               da = rnd_addr(); dw = 1'($urandom_range(0, 1)); dwd = $urandom;
               dp = 1'b1;
               d_start = d_acked ? cyc + 1 : cyc;
               bus.d_req = 1'b1; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dwd;
            end else begin
               bus.d_req = 1'b0; bus.d_we = 1'b0;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
